// File: rtl/spi_dac_sched_pkg.sv
// Shared types and frame layout for the SPI DAC scheduler.
// The frame builder is the single place that knows the DAC command word format.
package spi_dac_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      GAP,
      LDAC
   } state_t;

   localparam int FRAME_SEL_BIT  = 15;
   localparam int FRAME_GA_BIT   = 13;
   localparam int FRAME_SHDN_BIT = 12;
   localparam int FRAME_DATA_MSB = 11;
   localparam int FRAME_DATA_LSB = 4;

   function automatic logic [15:0] build_frame(input logic       sel,
                                               input logic       ga_n,
                                               input logic       shdn_n,
                                               input logic [7:0] code);
      logic [15:0] word;
      word                                = '0;
      word[FRAME_SEL_BIT]                 = sel;
      word[FRAME_GA_BIT]                  = ga_n;
      word[FRAME_SHDN_BIT]                = shdn_n;
      word[FRAME_DATA_MSB:FRAME_DATA_LSB] = code;
      return word;
   endfunction

endpackage

// File: rtl/spi_dac_sched_rr_arbiter.sv
// Combinational round-robin picker: first pending channel at or after ptr, wrapping.
// The pointer register itself lives in the parent so it only moves when a grant is taken.
module spi_dac_rr_arbiter
   import spi_dac_sched_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int PTR_W = 1
) (
   input  logic [N_CH-1:0]  pending,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] grant,
   output logic             grant_valid
);

   int idx;

   // Scan from the farthest offset down so the nearest pending channel wins last.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N_CH;
         if (pending[idx]) begin
            grant       = PTR_W'(idx);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_dac_scheduler.sv
// Shares one SPI DAC frame engine between N_CH requesters with round-robin
// arbitration, an enforced inter-frame gap and an LDAC strobe after each sweep.
module spi_dac_scheduler
   import spi_dac_sched_pkg::*;
#(
   parameter int N_CH           = 2,
   parameter int GAP_CYCLES     = 4,
   parameter int LDAC_CYCLES    = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [N_CH-1:0]   req_valid,
   input  logic [8*N_CH-1:0] req_data,
   output logic [N_CH-1:0]   req_ready,
   input  logic              cfg_ga_n,
   input  logic              cfg_shdn_n,
   output logic              spi_start,
   output logic [15:0]       spi_word,
   output logic              spi_dev_sel,
   input  logic              spi_done,
   output logic              ldac_n,
   output logic              busy,
   output logic              err_timeout,
   input  logic              err_clr
);

   localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int MAX_A   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int MAX_CNT = (MAX_A > LDAC_CYCLES) ? MAX_A : LDAC_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   state_t           state, state_next;
   logic [N_CH-1:0]  pending, accept, clr_mask;
   logic [7:0]       code_q [N_CH];
   logic [PTR_W-1:0] ptr, grant, grant_q;
   logic [1:0]       grant_ch;
   logic             grant_valid, take, clr, timeout_set;
   logic [CNT_W-1:0] cnt, cnt_next;

   spi_dac_rr_arbiter #(
      .N_CH  (N_CH),
      .PTR_W (PTR_W)
   ) u_arbiter (
      .pending     (pending),
      .ptr         (ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign accept    = req_valid & ~pending;
   assign req_ready = ~pending;
   assign busy      = (state != IDLE) || (|pending);
   assign grant_ch  = 2'(grant);

   always_comb begin
      clr_mask = '0;
      for (int c = 0; c < N_CH; c++) begin
         clr_mask[c] = clr && (grant_q == PTR_W'(c));
      end
   end

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      take        = 1'b0;
      clr         = 1'b0;
      timeout_set = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (grant_valid) begin
               take       = 1'b1;
               state_next = START;
            end
         end
         START: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            if (spi_done) begin
               clr        = 1'b1;
               cnt_next   = '0;
               state_next = GAP;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_set = 1'b1;
               clr         = 1'b1;
               cnt_next    = '0;
               state_next  = GAP;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         GAP: begin
            // A request landing on the last gap edge still counts, so LDAC waits for it.
            if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
               cnt_next   = '0;
               state_next = ((|pending) || (|accept)) ? IDLE : LDAC;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         LDAC: begin
            if (cnt == CNT_W'(LDAC_CYCLES - 1)) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // Strobes are registered from the next state so they match the state cycle-for-cycle.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         pending     <= '0;
         ptr         <= '0;
         grant_q     <= '0;
         spi_word    <= '0;
         spi_dev_sel <= 1'b0;
         spi_start   <= 1'b0;
         ldac_n      <= 1'b1;
         err_timeout <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         pending   <= (pending | accept) & ~clr_mask;
         spi_start <= (state_next == START);
         ldac_n    <= (state_next != LDAC);
         if (take) begin
            grant_q     <= grant;
            ptr         <= (grant == PTR_W'(N_CH - 1)) ? '0 : grant + PTR_W'(1);
            spi_word    <= build_frame(grant_ch[0], cfg_ga_n, cfg_shdn_n, code_q[grant]);
            spi_dev_sel <= grant_ch[1];
         end
         if (timeout_set) begin
            err_timeout <= 1'b1;
         end else if (err_clr) begin
            err_timeout <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (accept[c]) begin
            code_q[c] <= req_data[8*c +: 8];
         end
      end
   end

endmodule

// File: tb/tb_spi_dac_scheduler.sv
// Scoreboard bench for spi_dac_scheduler: expected frames are queued when requests
// are accepted and popped when the DUT pulses spi_start.
module tb_spi_dac_scheduler;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        cfg_ga_n, cfg_shdn_n;
   logic        spi_start;
   logic [15:0] spi_word;
   logic        spi_dev_sel;
   logic        spi_done;
   logic        manual_done = 1'b0;
   logic        auto_done = 1'b0;
   logic        ldac_n, busy, err_timeout, err_clr;

   logic [16:0] exp_q [$];
   logic [16:0] exp_item;
   int          checks = 0;
   int          errors = 0;
   int          start_cnt = 0;
   int          ldac_cnt = 0;
   int          ldac_at_start = 0;
   logic        prev_ldac = 1'b1;
   bit          done_en = 1'b0;
   int          done_timer = -1;
   int          n, s0, s1, l0;

   always #5 clk = ~clk;

   assign spi_done = manual_done | auto_done;

   spi_dac_scheduler #(
      .N_CH           (4),
      .GAP_CYCLES     (4),
      .LDAC_CYCLES    (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .cfg_ga_n    (cfg_ga_n),
      .cfg_shdn_n  (cfg_shdn_n),
      .spi_start   (spi_start),
      .spi_word    (spi_word),
      .spi_dev_sel (spi_dev_sel),
      .spi_done    (spi_done),
      .ldac_n      (ldac_n),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_clr     (err_clr)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic void pushExp(input int ch, input logic [7:0] code);
      logic [1:0] c;
      c = 2'(ch);
      exp_q.push_back({c[1], c[0], 1'b0, cfg_ga_n, cfg_shdn_n, code, 4'b0000});
   endfunction

   // Holds req_valid until the channel is ready, then queues the frame it must produce.
   task automatic applyStimulus(input int ch, input logic [7:0] code);
      int k;
      req_valid[ch]       = 1'b1;
      req_data[8*ch +: 8] = code;
      k = 0;
      while (!req_ready[ch] && k < 200) begin
         @(negedge clk);
         k++;
      end
      checkOutput("req_accept", req_ready[ch], 1'b1);
      pushExp(ch, code);
      @(negedge clk);
      req_valid[ch] = 1'b0;
   endtask

   task automatic waitIdle(input int limit);
      int k;
      k = 0;
      while ((busy || exp_q.size() != 0) && k < limit) begin
         @(negedge clk);
         k++;
      end
      checkOutput("idle_reached", busy, 1'b0);
      checkOutput("sb_drained", exp_q.size(), 0);
   endtask

   task automatic doReset();
      n_rst       = 1'b0;
      req_valid   = '0;
      req_data    = '0;
      err_clr     = 1'b0;
      manual_done = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_start", spi_start, 1'b0);
      checkOutput("rst_word", spi_word, 16'h0000);
      checkOutput("rst_dev_sel", spi_dev_sel, 1'b0);
      checkOutput("rst_ldac_n", ldac_n, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_err", err_timeout, 1'b0);
      checkOutput("rst_ready", req_ready, 4'hF);
      exp_q.delete();
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   // Frame engine model: answers each start with spi_done three cycles later.
   always @(negedge clk) begin
      auto_done = 1'b0;
      if (done_en) begin
         if (done_timer == 0) begin
            auto_done  = 1'b1;
            done_timer = -1;
         end else if (done_timer > 0) begin
            done_timer--;
         end
         if (spi_start) done_timer = 2;
      end else begin
         done_timer = -1;
      end
   end

   always @(negedge clk) begin
      if (spi_start) begin
         start_cnt++;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_start", spi_start, 1'b0);
         end else begin
            exp_item = exp_q.pop_front();
            checkOutput("spi_word", spi_word, exp_item[15:0]);
            checkOutput("spi_dev_sel", spi_dev_sel, exp_item[16]);
         end
      end
      if (!ldac_n && prev_ldac) begin
         ldac_cnt++;
         ldac_at_start = start_cnt;
      end
      prev_ldac = ldac_n;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cfg_ga_n   = 1'b1;
      cfg_shdn_n = 1'b1;
      err_clr    = 1'b0;

      $display("[TB] single write with latency, gap and ldac timing");
      doReset();
      done_en = 1'b0;
      applyStimulus(0, 8'h78);
      checkOutput("start_early", spi_start, 1'b0);
      @(negedge clk);
      checkOutput("start_latency", spi_start, 1'b1);
      manual_done = 1'b1;
      @(negedge clk);
      manual_done = 1'b0;
      checkOutput("start_width", spi_start, 1'b0);
      checkOutput("word_hold", spi_word, 16'h3780);
      checkOutput("done_in_start_ignored", req_ready[0], 1'b0);
      @(negedge clk);
      manual_done = 1'b1;
      @(negedge clk);
      manual_done = 1'b0;
      checkOutput("ready_after_done", req_ready[0], 1'b1);
      for (int i = 0; i < 7; i++) begin
         checkOutput("ldac_seq", ldac_n, (i == 4 || i == 5) ? 1'b0 : 1'b1);
         @(negedge clk);
      end
      checkOutput("single_busy", busy, 1'b0);

      $display("[TB] fairness between two simultaneous requests");
      doReset();
      done_en = 1'b1;
      s0 = start_cnt;
      l0 = ldac_cnt;
      req_data[7:0]  = 8'h11;
      req_data[15:8] = 8'hA5;
      req_valid      = 4'b0011;
      pushExp(0, 8'h11);
      pushExp(1, 8'hA5);
      @(negedge clk);
      req_valid = '0;
      waitIdle(200);
      checkOutput("fair_frames", start_cnt - s0, 2);
      checkOutput("fair_ldac_count", ldac_cnt - l0, 1);
      checkOutput("fair_ldac_after_last", ldac_at_start - s0, 2);

      $display("[TB] back-pressure on a pending channel");
      doReset();
      done_en = 1'b1;
      applyStimulus(0, 8'h33);
      req_valid[0]  = 1'b1;
      req_data[7:0] = 8'h22;
      checkOutput("bp_ready_low", req_ready[0], 1'b0);
      applyStimulus(0, 8'h22);
      waitIdle(300);

      $display("[TB] timeout with err_clr held, then sticky flag and clear");
      doReset();
      done_en    = 1'b0;
      cfg_shdn_n = 1'b0;
      err_clr    = 1'b1;
      l0 = ldac_cnt;
      applyStimulus(2, 8'h5A);
      n = 0;
      while (!spi_start && n < 10) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!err_timeout && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("timeout_cycles", n, 17);
      err_clr = 1'b0;
      checkOutput("timeout_ready", req_ready[2], 1'b1);
      waitIdle(100);
      checkOutput("timeout_ldac", ldac_cnt - l0, 1);
      checkOutput("err_sticky", err_timeout, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checkOutput("err_cleared", err_timeout, 1'b0);
      cfg_shdn_n = 1'b1;

      $display("[TB] reset in the middle of a frame");
      doReset();
      done_en = 1'b0;
      s0 = start_cnt;
      req_data[7:0]  = 8'h40;
      req_data[15:8] = 8'h41;
      req_valid      = 4'b0011;
      pushExp(0, 8'h40);
      pushExp(1, 8'h41);
      @(negedge clk);
      req_valid = '0;
      n = 0;
      while (start_cnt == s0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      s1 = start_cnt;
      l0 = ldac_cnt;
      n_rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_ldac_n", ldac_n, 1'b1);
      checkOutput("midrst_ready", req_ready, 4'hF);
      exp_q.delete();
      n_rst = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("midrst_no_start", start_cnt - s1, 0);
      checkOutput("midrst_no_ldac", ldac_cnt - l0, 0);

      $display("[TB] channel 3 with gain bit low");
      doReset();
      done_en    = 1'b1;
      cfg_ga_n   = 1'b0;
      cfg_shdn_n = 1'b1;
      applyStimulus(3, 8'hFF);
      waitIdle(100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_dac_scheduler.md
Name: spi_dac_scheduler

Overview:
- Shares one SPI DAC frame engine between N_CH requesters, one 8-bit DAC code per requester.
- Arbitrates round-robin, builds the 16-bit frame word, pulses the engine start and waits for its completion.
- Enforces a minimum inter-frame gap, then pulses LDAC once a sweep of pending channels is finished.
- Sits between application logic (waveform or setpoint sources) and the SPI DAC shifter.

Parameters:
- N_CH, 2: requester count, legal 1..4. Channel c maps to DAC select bit c[0] and device select c[1].
- GAP_CYCLES, 4: minimum clk cycles between spi_done and the next spi_start. Legal >= 1.
- LDAC_CYCLES, 2: width of the ldac_n low pulse in clk cycles. Legal >= 1.
- TIMEOUT_CYCLES, 65535: maximum clk cycles to wait for spi_done. Legal >= 2.

Ports:
- clk, in, 1: system clock.
- n_rst, in, 1: reset, synchronous, active-low.
- req_valid, in, N_CH: per-channel write request.
- req_data, in, 8*N_CH: DAC code; channel c uses bits [8c+7:8c].
- req_ready, out, N_CH: channel c can accept a write; equals !pending[c].
- cfg_ga_n, in, 1: gain bit for frames; 1 = 1x.
- cfg_shdn_n, in, 1: output-enable bit for frames; 1 = active.
- spi_start, out, 1: one-cycle start pulse to the frame engine.
- spi_word, out, 16: frame word, held stable from spi_start until spi_done.
- spi_dev_sel, out, 1: device select, equal to the granted channel's bit 1.
- spi_done, in, 1: one-cycle completion pulse from the frame engine.
- ldac_n, out, 1: DAC latch strobe, active-low.
- busy, out, 1: high whenever the FSM is not in IDLE or any channel is pending.
- err_timeout, out, 1: sticky timeout flag.
- err_clr, in, 1: clears err_timeout.

Behaviour:
- Reset (n_rst low at a clk edge):
  - FSM goes to IDLE; pending cleared; round-robin pointer set to channel 0 (channel 0 has first priority).
  - Outputs: spi_start=0, spi_word=0, spi_dev_sel=0, ldac_n=1, busy=0, err_timeout=0, req_ready all 1.
- Reset mid-frame: abandon the frame immediately; drop all pending data; no LDAC pulse is issued.
- Request buffer:
  - One holding register per channel. req_valid[c] && req_ready[c] at an edge latches the code and sets pending[c].
  - req_valid while not ready is ignored; the requester must hold it.
- Frame word: {c[0], 1'b0, cfg_ga_n, cfg_shdn_n, code[7:0], 4'b0000}. The cfg inputs are sampled when the grant is taken.
- FSM states:
  - IDLE: if any pending, grant the first pending channel at or after the pointer (wrapping). Register spi_word and spi_dev_sel, advance the pointer to grant+1 mod N_CH, go to START.
  - START: spi_start=1 for exactly one cycle, clear the timeout counter, go to WAIT. A spi_done arriving in START is ignored.
  - WAIT:
    - On spi_done: clear pending[grant] and go to GAP.
    - If the counter reaches TIMEOUT_CYCLES first: set err_timeout, clear pending[grant] and go to GAP.
  - GAP: count GAP_CYCLES. At the end, go to LDAC if no channel is pending, otherwise go to IDLE.
  - LDAC: ldac_n=0 for LDAC_CYCLES cycles, then go to IDLE.
- Latency: a handshake in cycle 0 with the FSM idle gives spi_start=1 in cycle 2.
- Boundary cases:
  - A channel re-requesting in the same cycle its pending clears is not accepted. req_ready rises the cycle after the spi_done edge.
  - spi_done outside WAIT is ignored.
  - If err_clr and a timeout event occur in the same cycle, the set wins.
  - A request arriving during GAP prevents the LDAC pulse. It is served after GAP, and LDAC follows that frame instead.
  - N_CH=1: the arbiter degenerates to a single channel; spi_dev_sel=0.

Decomposition:
- Package spi_dac_sched_pkg holds:
  - state enum (IDLE, START, WAIT, GAP, LDAC);
  - frame bit positions (SEL=15, GA=13, SHDN=12, DATA=11:4);
  - frame-build function.
- Sub-module spi_dac_rr_arbiter: pending vector and pointer in, grant index and grant_valid out, purely combinational. Round-robin pointer stays in the parent.

Test Plan:
- Single write: ch0 code 0x78, ga_n=1, shdn_n=1 → spi_start in cycle 2 with spi_word=0x3780, dev_sel=0. spi_done → GAP of 4 cycles, then ldac_n low for 2 cycles. req_ready[0] is high the cycle after spi_done.
- Fairness: ch0=0x11 and ch1=0xA5 requested in the same cycle after reset → frames 0x3110 then 0xBA50. Exactly one LDAC pulse, after the second frame.
- Back-pressure: ch0 re-asserts req_valid with code 0x22 while pending → req_ready[0]=0 and the code is not latched. Accepted after its frame; the next frame carries 0x3220.
- Timeout: TIMEOUT_CYCLES=16, spi_done never asserted → err_timeout=1 after 16 WAIT cycles; pending cleared; FSM back to IDLE via GAP and LDAC. err_clr pulse → err_timeout=0.
- Reset mid-frame: n_rst low during WAIT with ch1 pending → next cycle IDLE, busy=0, ldac_n=1, all req_ready=1. No spi_start until a new request.
- N_CH=4: ch3 code 0xFF, ga_n=0, shdn_n=1 → spi_word=0x9FF0, spi_dev_sel=1.
